// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@60 timing constants (horizontal in pixels, vertical in
//     lines) and default sync polarities
//   - vga_ctrl_t, the {hsync, vsync, blank_b} bundle carried by the delay line
//   - vga_total(), which sums the four segments of a line or a frame
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam bit VGA_HSYNC_POL = 1'b0;
    localparam bit VGA_VSYNC_POL = 1'b0;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_b;
    } vga_ctrl_t;

    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the pixel enable and all raster outputs of vga_timing_gen.
//   en                      : pixel enable (consumer -> generator)
//   x, y                    : undelayed pixel counters
//   active, line_start,
//   frame_start             : undelayed decodes of x/y
//   hsync, vsync, blank_b   : sync/blank delayed to match the pixel read path
// modport master : the timing generator
// modport slave  : the consumer (frame-buffer read port / pin driver)
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);

    logic          en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          active;
    logic          line_start;
    logic          frame_start;
    logic          hsync;
    logic          vsync;
    logic          blank_b;

    modport master (
        input  en,
        output x, y, active, line_start, frame_start, hsync, vsync, blank_b
    );

    modport slave (
        output en,
        input  x, y, active, line_start, frame_start, hsync, vsync, blank_b
    );

endinterface

// File: rtl/vga_timing_gen_pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
// Enable-gated delay line, DEPTH stages of WIDTH bits. The line shifts only on
// cycles with en=1 and holds otherwise. Synchronous reset loads every stage
// with RESET_VAL so nothing stale emerges after a reset. DEPTH=0 is a wire.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : shift enable
//   d          : input word
//   q          : d delayed by DEPTH enabled cycles
//   RESET_VAL  : value loaded into every stage on reset
// -----------------------------------------------------------------------------
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] RESET_VAL
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, en, RESET_VAL};
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i];
                end
                if (en) begin
                    stage_d[0] = d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (reset) begin
                        stage_q[i] <= RESET_VAL;
                    end else begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. x counts pixels across a line,
// y counts lines down a frame; both advance only on pixel-enable cycles.
// Sync and blank are decoded from x/y and then delayed PIPE enabled cycles so
// they line up with a pixel store addressed by the undelayed x/y.
// Ports:
//   clk   : pixel clock
//   reset : synchronous, active-high
//   vif   : master side of vga_timing_gen_if (en in; x, y, active,
//           line_start, frame_start, hsync, vsync, blank_b out)
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter bit HSYNC_POL = VGA_HSYNC_POL,
    parameter bit VSYNC_POL = VGA_VSYNC_POL,
    parameter int PIPE      = 2,
    parameter int XW        = 10,
    parameter int YW        = 10
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vif
);

    localparam int H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Every boundary is strictly below the total because the back porch is
    // non-zero, so all of them fit in XW/YW bits.
    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HS_START = XW'(HS_START);
    localparam logic [XW-1:0] X_HS_END   = XW'(HS_END);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VS_START = YW'(VS_START);
    localparam logic [YW-1:0] Y_VS_END   = YW'(VS_END);

    // Deasserted syncs and blanked video: the reset value of every delay stage.
    localparam vga_ctrl_t CTRL_IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, blank_b: 1'b0};

    generate
        if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
            $error("vga_timing_gen: every active/porch/sync width must be non-zero");
        end
        if (PIPE < 0 || PIPE > 8) begin : g_bad_pipe
            $error("vga_timing_gen: PIPE must be in 0..8");
        end
        if (XW < 1 || XW > 30 || H_TOTAL > (1 << XW)) begin : g_bad_xw
            $error("vga_timing_gen: XW too narrow for H_TOTAL");
        end
        if (YW < 1 || YW > 30 || V_TOTAL > (1 << YW)) begin : g_bad_yw
            $error("vga_timing_gen: YW too narrow for V_TOTAL");
        end
    endgenerate

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // y steps only on the x wrap, so both counters roll over together at the
    // end of the frame.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (vif.en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    logic      active;
    logic      h_in_sync;
    logic      v_in_sync;
    vga_ctrl_t ctrl_raw;
    vga_ctrl_t ctrl_dly;

    assign active    = (x_q < X_ACT_END) && (y_q < Y_ACT_END);
    assign h_in_sync = (x_q >= X_HS_START) && (x_q < X_HS_END);
    // vsync spans whole lines, so it depends on y only.
    assign v_in_sync = (y_q >= Y_VS_START) && (y_q < Y_VS_END);

    always_comb begin
        ctrl_raw.hsync   = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
        ctrl_raw.vsync   = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
        ctrl_raw.blank_b = active;
    end

    pipe_delay #(
        .WIDTH ($bits(vga_ctrl_t)),
        .DEPTH (PIPE)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .en        (vif.en),
        .d         (ctrl_raw),
        .q         (ctrl_dly),
        .RESET_VAL (CTRL_IDLE)
    );

    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.active      = active;
    assign vif.line_start  = (x_q == '0);
    assign vif.frame_start = (x_q == '0) && (y_q == '0);
    assign vif.hsync       = ctrl_dly.hsync;
    assign vif.vsync       = ctrl_dly.vsync;
    assign vif.blank_b     = ctrl_dly.blank_b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators share one clock: the default 640x480 timing, a mid-sized
// configuration (PIPE=3) small enough to cover whole frames, and the tiny
// 8x5 configuration with positive syncs and PIPE=0. A raster model derives
// every output from the count of enabled cycles since reset and is compared
// against each DUT on every falling edge; directed sequences pin the model
// with hand-computed values and measure pulse positions and periods.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def, rst_mid, rst_sml;

    vga_timing_gen_if #(.XW(10), .YW(10)) if_def ();
    vga_timing_gen_if #(.XW(5),  .YW(4))  if_mid ();
    vga_timing_gen_if #(.XW(3),  .YW(3))  if_sml ();

    vga_timing_gen u_def (
        .clk   (clk),
        .reset (rst_def),
        .vif   (if_def)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE(3), .XW(5), .YW(4)
    ) u_mid (
        .clk   (clk),
        .reset (rst_mid),
        .vif   (if_mid)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE(0), .XW(3), .YW(3)
    ) u_sml (
        .clk   (clk),
        .reset (rst_sml),
        .vif   (if_sml)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raster model: n enabled cycles since reset. Undelayed outputs come from
    // position n; delayed outputs from position n-pipe, idle while n < pipe.
    // Packed as {x[11:0], y[11:0], active, line_start, frame_start,
    //            hsync, vsync, blank_b, 2'b00}.
    function automatic logic [31:0] model_vec(input int n,
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input bit hp, input bit vp, input int pipe);
        int   ht, vt, x, y, m, xm, ym;
        logic a, ls, fs, hsy, vsy, bb;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        x   = n % ht;
        y   = (n / ht) % vt;
        a   = (x < ha) && (y < va);
        ls  = (x == 0);
        fs  = (x == 0) && (y == 0);
        hsy = ~hp;
        vsy = ~vp;
        bb  = 1'b0;
        if (n >= pipe) begin
            m  = n - pipe;
            xm = m % ht;
            ym = (m / ht) % vt;
            if (xm >= ha + hf && xm < ha + hf + hs) hsy = hp;
            if (ym >= va + vf && ym < va + vf + vs) vsy = vp;
            bb = (xm < ha) && (ym < va);
        end
        return {x[11:0], y[11:0], a, ls, fs, hsy, vsy, bb, 2'b00};
    endfunction

    function automatic logic [31:0] vec_def();
        return {12'(if_def.x), 12'(if_def.y), if_def.active, if_def.line_start,
                if_def.frame_start, if_def.hsync, if_def.vsync, if_def.blank_b, 2'b00};
    endfunction

    function automatic logic [31:0] vec_mid();
        return {12'(if_mid.x), 12'(if_mid.y), if_mid.active, if_mid.line_start,
                if_mid.frame_start, if_mid.hsync, if_mid.vsync, if_mid.blank_b, 2'b00};
    endfunction

    function automatic logic [31:0] vec_sml();
        return {12'(if_sml.x), 12'(if_sml.y), if_sml.active, if_sml.line_start,
                if_sml.frame_start, if_sml.hsync, if_sml.vsync, if_sml.blank_b, 2'b00};
    endfunction

    int n_def = 0;
    int n_mid = 0;
    int n_sml = 0;

    always @(posedge clk) begin
        n_def <= rst_def ? 0 : (if_def.en ? n_def + 1 : n_def);
        n_mid <= rst_mid ? 0 : (if_mid.en ? n_mid + 1 : n_mid);
        n_sml <= rst_sml ? 0 : (if_sml.en ? n_sml + 1 : n_sml);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("def_cycle", vec_def(), model_vec(n_def, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2));
            chk("mid_cycle", vec_mid(), model_vec(n_mid, 16, 2, 3, 2, 6, 2, 2, 3, 1'b0, 1'b0, 3));
            chk("sml_cycle", vec_sml(), model_vec(n_sml, 4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1, 0));
        end
    end

    initial begin
        int          k, fall1, rise1, fall2, r1, r2;
        logic        prev, last_en;
        logic [31:0] pv, cv;

        rst_def = 1'b1; rst_mid = 1'b1; rst_sml = 1'b1;
        if_def.en = 1'b1; if_mid.en = 1'b1; if_sml.en = 1'b1;
        step();
        step();
        chk_on = 1'b1;

        // Reset state (cycle 0)
        chk("rst_def_x",       32'(if_def.x), 32'd0);
        chk("rst_def_y",       32'(if_def.y), 32'd0);
        chk("rst_def_hsync",   32'(if_def.hsync), 32'd1);
        chk("rst_def_vsync",   32'(if_def.vsync), 32'd1);
        chk("rst_def_blank",   32'(if_def.blank_b), 32'd0);
        chk("rst_def_fstart",  32'(if_def.frame_start), 32'd1);
        chk("rst_def_active",  32'(if_def.active), 32'd1);
        chk("rst_mid_blank",   32'(if_mid.blank_b), 32'd0);
        chk("rst_sml_hsync",   32'(if_sml.hsync), 32'd0);
        chk("rst_sml_blank",   32'(if_sml.blank_b), 32'd1);
        rst_def = 1'b0; rst_mid = 1'b0; rst_sml = 1'b0;

        step();
        chk("def_c1_blank", 32'(if_def.blank_b), 32'd0);
        chk("def_c1_hsync", 32'(if_def.hsync), 32'd1);
        chk("def_c1_x",     32'(if_def.x), 32'd1);
        step();
        chk("def_c2_blank", 32'(if_def.blank_b), 32'd1);

        // Small 8x5 raster, PIPE=0, positive syncs
        rst_sml = 1'b1;
        step();
        rst_sml = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            case (c)
                0: begin
                    chk("sml_c0_xy",    32'({if_sml.x, if_sml.y}), 32'd0);
                    chk("sml_c0_fs",    32'(if_sml.frame_start), 32'd1);
                    chk("sml_c0_hsync", 32'(if_sml.hsync), 32'd0);
                end
                4: begin
                    chk("sml_c4_active", 32'(if_sml.active), 32'd0);
                    chk("sml_c4_blank",  32'(if_sml.blank_b), 32'd0);
                    chk("sml_c4_hsync",  32'(if_sml.hsync), 32'd0);
                end
                5: begin
                    chk("sml_c5_x",     32'(if_sml.x), 32'd5);
                    chk("sml_c5_hsync", 32'(if_sml.hsync), 32'd1);
                end
                6: chk("sml_c6_hsync", 32'(if_sml.hsync), 32'd1);
                7: begin
                    chk("sml_c7_x",     32'(if_sml.x), 32'd7);
                    chk("sml_c7_hsync", 32'(if_sml.hsync), 32'd0);
                end
                8: begin
                    chk("sml_c8_x",  32'(if_sml.x), 32'd0);
                    chk("sml_c8_y",  32'(if_sml.y), 32'd1);
                    chk("sml_c8_ls", 32'(if_sml.line_start), 32'd1);
                    chk("sml_c8_fs", 32'(if_sml.frame_start), 32'd0);
                    chk("sml_c8_blank", 32'(if_sml.blank_b), 32'd1);
                end
                27: begin
                    chk("sml_c27_y",      32'(if_sml.y), 32'd3);
                    chk("sml_c27_vsync",  32'(if_sml.vsync), 32'd1);
                    chk("sml_c27_active", 32'(if_sml.active), 32'd0);
                end
                32: chk("sml_c32_vsync", 32'(if_sml.vsync), 32'd0);
                39: chk("sml_c39_xy", 32'({if_sml.x, if_sml.y}), 32'({3'd7, 3'd4}));
                40: begin
                    chk("sml_c40_xy", 32'({if_sml.x, if_sml.y}), 32'd0);
                    chk("sml_c40_fs", 32'(if_sml.frame_start), 32'd1);
                end
                default: ;
            endcase
            if (c < 40) step();
        end

        // Default hsync position, width and period
        rst_def = 1'b1;
        step();
        rst_def = 1'b0;
        k = 0;
        while (if_def.x != 10'd656 && k < 1000) begin
            step();
            k++;
        end
        chk("def_reach_x656", 32'(if_def.x), 32'd656);
        fall1 = -1; rise1 = -1; fall2 = -1;
        prev = if_def.hsync;
        for (int i = 1; i <= 900; i++) begin
            step();
            if (prev && !if_def.hsync) begin
                if (fall1 < 0) fall1 = i;
                else if (fall2 < 0) fall2 = i;
            end
            if (!prev && if_def.hsync && rise1 < 0) rise1 = i;
            prev = if_def.hsync;
        end
        chk("def_hs_fall",   32'(fall1), 32'd2);
        chk("def_hs_rise",   32'(rise1), 32'd98);
        chk("def_hs_period", 32'(fall2 - fall1), 32'd800);

        // Default with en toggling every cycle
        r1 = -1; r2 = -1;
        pv = vec_def();
        prev = if_def.line_start;
        for (int i = 1; i <= 3500 && r2 < 0; i++) begin
            last_en = if_def.en;
            step();
            cv = vec_def();
            if (!last_en) chk("def_hold_en0", cv, pv);
            if (!prev && if_def.line_start) begin
                if (r1 < 0) r1 = i;
                else r2 = i;
            end
            prev = if_def.line_start;
            pv = cv;
            if_def.en = ~if_def.en;
        end
        chk("def_en_line_period", 32'(r2 - r1), 32'd1600);
        if_def.en = 1'b1;

        // Mid configuration: vsync window and frame period
        rst_mid = 1'b1;
        step();
        rst_mid = 1'b0;
        k = 0;
        while (!(if_mid.x == 5'd0 && if_mid.y == 4'd8) && k < 400) begin
            step();
            k++;
        end
        chk("mid_reach_y8", 32'({if_mid.x, if_mid.y}), 32'({5'd0, 4'd8}));
        fall1 = -1; rise1 = -1;
        prev = if_mid.vsync;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (prev && !if_mid.vsync && fall1 < 0) fall1 = i;
            if (!prev && if_mid.vsync && rise1 < 0) rise1 = i;
            prev = if_mid.vsync;
        end
        chk("mid_vs_fall", 32'(fall1), 32'd3);
        chk("mid_vs_rise", 32'(rise1), 32'd49);

        r1 = -1; r2 = -1;
        prev = if_mid.frame_start;
        for (int i = 1; i <= 700 && r2 < 0; i++) begin
            step();
            if (!prev && if_mid.frame_start) begin
                if (r1 < 0) r1 = i;
                else r2 = i;
            end
            prev = if_mid.frame_start;
        end
        chk("mid_frame_period", 32'(r2 - r1), 32'd299);

        // Reset in the middle of an hsync pulse on a vsync line
        k = 0;
        while (!(if_mid.x == 5'd19 && if_mid.y == 4'd8) && k < 400) begin
            step();
            k++;
        end
        chk("mid_reach_x19y8", 32'({if_mid.x, if_mid.y}), 32'({5'd19, 4'd8}));
        rst_mid = 1'b1;
        step();
        rst_mid = 1'b0;
        chk("mid_rst_xy", 32'({if_mid.x, if_mid.y}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("mid_rst_hsync", 32'(if_mid.hsync), 32'd1);
            chk("mid_rst_vsync", 32'(if_mid.vsync), 32'd1);
            chk("mid_rst_blank", 32'(if_mid.blank_b), 32'd0);
            step();
        end
        chk("mid_rst_c3_blank", 32'(if_mid.blank_b), 32'd1);
        chk("mid_rst_c3_x",     32'(if_mid.x), 32'd3);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
